clk_meas: RTL

CLK_MEAS -- requirements
Module: clk_meas

---
 rtl/clk_meas_pkg.sv | 24 ++
 rtl/clk_meas_sync.sv | 64 ++++++
 rtl/clk_meas.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/clk_meas_pkg.sv
// Shared types and constants for the clk_meas clock/phase measurement block.
// Optional glitch filter is enabled with macro CLK_MEAS_GLITCH_FILT_EN.
package clk_meas_pkg;

  localparam int CNT_W_DEF       = 16;
  localparam int SYNC_STAGES_DEF = 2;

  // Extra edge-detect latency added by the glitch filter, identical on both inputs.
`ifdef CLK_MEAS_GLITCH_FILT_EN
  localparam int FILT_LAT = 1;
`else
  localparam int FILT_LAT = 0;
`endif

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_REF  = 3'd1,
    WAIT_RISE = 3'd2,
    MEAS_HIGH = 3'd3,
    MEAS_LOW  = 3'd4,
    DONE      = 3'd5
  } state_e;

endpackage

// File: rtl/clk_meas_sync.sv
// Synchronizer, optional 2-sample glitch filter (CLK_MEAS_GLITCH_FILT_EN) and
// rise/fall detect for one asynchronous input. SYNC_STAGES must be >= 2.
module clk_meas_sync
  import clk_meas_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  // Edges are masked until the chain (and filter) has flushed its reset contents.
  localparam int ARM_CYC = SYNC_STAGES + FILT_LAT + 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   smp_q;
  logic [ARM_CYC-1:0]     arm_q;
  logic                   lvl;
  logic                   rise_raw;
  logic                   fall_raw;

  assign lvl = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      smp_q  <= 1'b0;
      arm_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      smp_q  <= lvl;
      arm_q  <= {arm_q[ARM_CYC-2:0], 1'b1};
    end
  end

`ifdef CLK_MEAS_GLITCH_FILT_EN
  logic filt_q;
  logic filt_d;

  // Accept a new level only once two consecutive samples agree.
  assign filt_d = (lvl == smp_q) ? lvl : filt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      filt_q <= 1'b0;
    end else begin
      filt_q <= filt_d;
    end
  end

  assign rise_raw = filt_d & ~filt_q;
  assign fall_raw = ~filt_d & filt_q;
`else
  assign rise_raw = lvl & ~smp_q;
  assign fall_raw = ~lvl & smp_q;
`endif

  assign rise_o = rise_raw & arm_q[ARM_CYC-1];
  assign fall_o = fall_raw & arm_q[ARM_CYC-1];

endmodule

// File: rtl/clk_meas.sv
// Measures phase (ref rise -> sig rise), high time and period of sig_in in clk cycles.
// Glitch filtering on both inputs is enabled with macro CLK_MEAS_GLITCH_FILT_EN.
module clk_meas
  import clk_meas_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             ref_in,
  input  logic             start,
  output logic             busy,
  output logic             valid,
  output logic             err,
  output logic [CNT_W-1:0] phase_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  logic sig_rise;
  logic sig_fall;
  logic ref_rise;
  logic ref_fall_unused;

  clk_meas_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sig (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (sig_in),
    .rise_o (sig_rise),
    .fall_o (sig_fall)
  );

  clk_meas_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ref (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (ref_in),
    .rise_o (ref_rise),
    .fall_o (ref_fall_unused)
  );

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             busy_q;
  logic             valid_q;
  logic             err_q;
  logic [CNT_W-1:0] phase_q;
  logic [CNT_W-1:0] high_q;
  logic [CNT_W-1:0] period_q;
  // Shadows collect results during a measurement; outputs only change with valid.
  logic [CNT_W-1:0] ph_sh_q;
  logic [CNT_W-1:0] hi_sh_q;

  assign cnt_d = sat_inc(cnt_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      phase_q  <= '0;
      high_q   <= '0;
      period_q <= '0;
      ph_sh_q  <= '0;
      hi_sh_q  <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= WAIT_REF;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            ph_sh_q <= phase_q;
            hi_sh_q <= high_q;
          end
        end

        WAIT_REF, WAIT_RISE, MEAS_HIGH, MEAS_LOW: begin
          if (cnt_q == CNT_MAX) begin
            // Timeout: publish whatever was latched so far, keep the rest.
            state_q <= DONE;
            valid_q <= 1'b1;
            err_q   <= 1'b1;
            phase_q <= ph_sh_q;
            high_q  <= hi_sh_q;
          end else begin
            cnt_q <= cnt_d;
            case (state_q)
              WAIT_REF: begin
                if (ref_rise) begin
                  cnt_q <= '0;
                  if (sig_rise) begin
                    ph_sh_q <= '0;
                    state_q <= MEAS_HIGH;
                  end else begin
                    state_q <= WAIT_RISE;
                  end
                end
              end
              WAIT_RISE: begin
                if (sig_rise) begin
                  ph_sh_q <= cnt_d;
                  cnt_q   <= '0;
                  state_q <= MEAS_HIGH;
                end
              end
              MEAS_HIGH: begin
                if (sig_fall) begin
                  hi_sh_q <= cnt_d;
                  state_q <= MEAS_LOW;
                end
              end
              MEAS_LOW: begin
                if (sig_rise) begin
                  period_q <= cnt_d;
                  phase_q  <= ph_sh_q;
                  high_q   <= hi_sh_q;
                  valid_q  <= 1'b1;
                  err_q    <= 1'b0;
                  state_q  <= DONE;
                end
              end
              default: ;
            endcase
          end
        end

        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign valid      = valid_q;
  assign err        = err_q;
  assign phase_cnt  = phase_q;
  assign high_cnt   = high_q;
  assign period_cnt = period_q;

endmodule
